// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock/tick divider.
// Each channel counts 0..div_reg and emits a one-cycle tick after every
// terminal count (TC). Its divided_clk either toggles at TC (50 % duty) or
// pulses for one cycle (pulse mode). New divisor/mode settings arrive
// through a valid/ready port. They wait in a shadow register until the
// channel's next TC, so the output never glitches.
// Optional feature macro: CLK_DIV_MULTI_SYNC_EN adds a 'sync' input that
// restarts every enabled channel in phase.
module clk_div_multi #(
   parameter int               NUM_CH   = 4,
   parameter int               CNT_W    = 32,
   parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(62499999),
   parameter bit               DEF_MODE = 1'b0,
   localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic              sync,
`endif
   output logic [NUM_CH-1:0] divided_clk,
   output logic [NUM_CH-1:0] tick
);

   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  div_reg [NUM_CH];
   logic [CNT_W-1:0]  div_sh  [NUM_CH];
   logic [NUM_CH-1:0] mode_reg;
   logic [NUM_CH-1:0] mode_sh;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] en_q;
   logic              rst_n_q;
   logic              sel_pending;
   logic              sync_now;

`ifdef CLK_DIV_MULTI_SYNC_EN
   assign sync_now = sync;
`else
   assign sync_now = 1'b0;
`endif

   // Config accept: blocked during and right after reset, and while the
   // addressed channel still holds an unapplied shadow. Channel numbers
   // past NUM_CH are always accepted, and the write is then discarded.
   always_comb begin
      sel_pending = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) sel_pending = pending[i];
      end
      cfg_ready = rst_n & rst_n_q & ~sel_pending;
   end

   // Per-channel counter, output, shadow and apply logic. en_q holds the
   // counter at 0 for the first enabled cycle, so the first tick arrives
   // div+2 cycles after enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_n_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]         <= '0;
            div_reg[i]     <= DEF_DIV;
            div_sh[i]      <= DEF_DIV;
            mode_reg[i]    <= DEF_MODE;
            mode_sh[i]     <= DEF_MODE;
            pending[i]     <= 1'b0;
            en_q[i]        <= 1'b0;
            divided_clk[i] <= 1'b0;
            tick[i]        <= 1'b0;
         end
      end else begin
         rst_n_q <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            en_q[i] <= en[i];
            if (!(en[i] && en_q[i]) || sync_now) begin
               cnt[i]         <= '0;
               divided_clk[i] <= 1'b0;
               tick[i]        <= 1'b0;
               if (pending[i]) begin
                  div_reg[i]  <= div_sh[i];
                  mode_reg[i] <= mode_sh[i];
                  pending[i]  <= 1'b0;
               end
            end else if (cnt[i] == div_reg[i]) begin
               cnt[i]  <= '0;
               tick[i] <= 1'b1;
               if (pending[i] && (mode_sh[i] != mode_reg[i])) begin
                  divided_clk[i] <= 1'b0;
               end else if (mode_reg[i]) begin
                  divided_clk[i] <= 1'b1;
               end else begin
                  divided_clk[i] <= ~divided_clk[i];
               end
               if (pending[i]) begin
                  div_reg[i]  <= div_sh[i];
                  mode_reg[i] <= mode_sh[i];
                  pending[i]  <= 1'b0;
               end
            end else begin
               cnt[i]  <= cnt[i] + 1'b1;
               tick[i] <= 1'b0;
               if (mode_reg[i]) divided_clk[i] <= 1'b0;
            end
            if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
               div_sh[i]  <= cfg_div;
               mode_sh[i] <= cfg_mode;
               pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus for clk_div_multi.
// The reference model places TCs by arithmetic on the cycle index since
// each channel's epoch start. It is compared against the DUT on every cycle.
module tb_clk_div_multi;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 2;
   localparam longint DEF_DIV = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] en = '0;
   logic              cfg_valid = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic              cfg_mode = 1'b0;
   logic              sync = 1'b0;
   logic              cfg_ready;
   logic [NUM_CH-1:0] divided_clk;
   logic [NUM_CH-1:0] tick;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   longint m_div   [NUM_CH];
   bit     m_mode  [NUM_CH];
   longint m_shd   [NUM_CH];
   bit     m_shm   [NUM_CH];
   bit     m_pend  [NUM_CH];
   longint m_start [NUM_CH];
   bit     m_run   [NUM_CH];
   bit     m_out   [NUM_CH];
   bit     m_tick  [NUM_CH];
   bit     m_rstq = 1'b0;
   longint cyc = 0;

   clk_div_multi #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DEF_DIV  (8'd3),
      .DEF_MODE (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_div     (cfg_div),
      .cfg_mode    (cfg_mode),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync        (sync),
`endif
      .divided_clk (divided_clk),
      .tick        (tick)
   );

   // 100 MHz bench clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit modelReady();
      bit p;
      p = 1'b0;
      if (int'(cfg_ch) < NUM_CH) p = m_pend[int'(cfg_ch)];
      return rst_n && m_rstq && !p;
   endfunction

   // Advance the model across one rising edge using the present inputs.
   task automatic modelEdge();
      bit xfer;
      bit clr;
      bit active;
      xfer = cfg_valid && modelReady();
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF_DIV; m_mode[i] = 1'b0; m_pend[i] = 1'b0;
            m_run[i] = 1'b0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
            m_start[i] = cyc + 1;
         end
         m_rstq = 1'b0;
      end else begin
         m_rstq = 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            active = en[i] && m_run[i];
            clr = 1'b0;
            if (!active || sync) begin
               m_out[i] = 1'b0;
               m_tick[i] = 1'b0;
               if (m_pend[i]) begin
                  m_div[i] = m_shd[i]; m_mode[i] = m_shm[i]; m_pend[i] = 1'b0;
               end
               m_start[i] = cyc + 1;
            end else if (((cyc - m_start[i]) % (m_div[i] + 1)) == m_div[i]) begin
               m_tick[i] = 1'b1;
               if (m_pend[i]) begin
                  if (m_shm[i] != m_mode[i]) clr = 1'b1;
                  m_div[i] = m_shd[i]; m_mode[i] = m_shm[i]; m_pend[i] = 1'b0;
               end
               m_out[i] = clr ? 1'b0 : (m_mode[i] ? 1'b1 : ~m_out[i]);
               m_start[i] = cyc + 1;
            end else begin
               m_tick[i] = 1'b0;
               if (m_mode[i]) m_out[i] = 1'b0;
            end
            m_run[i] = en[i];
            if (xfer && (int'(cfg_ch) == i)) begin
               m_shd[i] = longint'(cfg_div); m_shm[i] = cfg_mode; m_pend[i] = 1'b1;
            end
         end
      end
      cyc++;
   endtask

   task automatic checkOutput();
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("divided_clk[%0d]@%0d", i, cyc), 32'(divided_clk[i]), 32'(m_out[i]));
         check($sformatf("tick[%0d]@%0d", i, cyc), 32'(tick[i]), 32'(m_tick[i]));
      end
   endtask

   // One clock cycle: drive, check cfg_ready, step model, check outputs.
   task automatic applyStimulus(input bit r, input logic [NUM_CH-1:0] e, input bit v,
                                input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d,
                                input bit m, input bit s);
      @(negedge clk);
      rst_n = r; en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d; cfg_mode = m;
`ifdef CLK_DIV_MULTI_SYNC_EN
      sync = s;
`else
      sync = 1'b0 & s;
`endif
      #1;
      check($sformatf("cfg_ready@%0d", cyc), 32'(cfg_ready), 32'(modelReady()));
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n, input logic [NUM_CH-1:0] e);
      for (int k = 0; k < n; k++) applyStimulus(1, e, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int first;
      int period;
      logic [NUM_CH-1:0] re;
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DEF_DIV; m_mode[i] = 0; m_shd[i] = DEF_DIV; m_shm[i] = 0;
         m_pend[i] = 0; m_start[i] = 0; m_run[i] = 0; m_out[i] = 0; m_tick[i] = 0;
      end
      $display("[TB] clk_div_multi bench start");

      // Reset defaults
      for (int k = 0; k < 3; k++) applyStimulus(0, 3'b111, 0, 0, 0, 0, 0);
      check("rst_divided_clk", 32'(divided_clk), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      idle(24, 3'b111);

      // Pulse mode on ch1
      applyStimulus(1, 3'b111, 1, 1, 8'd1, 1, 0);
      idle(12, 3'b111);

      // Back-pressure on ch0, ch1 accepted inside the window
      applyStimulus(1, 3'b111, 1, 0, 8'd2, 0, 0);
      for (int k = 0; k < 6; k++) applyStimulus(1, 3'b111, 1, 0, 8'd4, 0, 0);
      applyStimulus(1, 3'b111, 1, 1, 8'd2, 0, 0);
      idle(14, 3'b111);

      // Divisor 0, toggle mode on ch2
      applyStimulus(1, 3'b111, 1, 2, 8'd0, 0, 0);
      idle(10, 3'b111);

      // Disabled-channel apply on ch0, then first tick and period
      idle(2, 3'b110);
      applyStimulus(1, 3'b110, 1, 0, 8'd5, 0, 0);
      idle(1, 3'b110);
      first = 21;
      for (int j = 1; j <= 20; j++) begin
         applyStimulus(1, 3'b111, 0, 0, 0, 0, 0);
         if (tick[0] === 1'b1) begin first = j; break; end
      end
      check("first_tick_after_en", 32'(first), 32'd7);
      period = 21;
      for (int j = 1; j <= 20; j++) begin
         applyStimulus(1, 3'b111, 0, 0, 0, 0, 0);
         if (tick[0] === 1'b1) begin period = j; break; end
      end
      check("tick_period_div5", 32'(period), 32'd6);

      // Out-of-range channel is accepted and discarded
      applyStimulus(1, 3'b111, 1, 3, 8'd9, 1, 0);
      idle(6, 3'b111);

      // Pulse mode with divisor 0 on ch1
      applyStimulus(1, 3'b111, 1, 1, 8'd0, 1, 0);
      idle(8, 3'b111);

      // Transfer while en[1] falls in the same cycle
      applyStimulus(1, 3'b101, 1, 1, 8'd2, 0, 0);
      idle(2, 3'b101);
      idle(12, 3'b111);

      // Full-width divisor on ch2
      applyStimulus(1, 3'b111, 1, 2, 8'hFF, 0, 0);
      idle(530, 3'b111);

      // Reset mid-operation with a pending write
      applyStimulus(1, 3'b111, 1, 0, 8'd7, 1, 0);
      applyStimulus(0, 3'b111, 0, 0, 0, 0, 0);
      check("midrst_divided_clk", 32'(divided_clk), 32'd0);
      check("midrst_tick", 32'(tick), 32'd0);
      idle(20, 3'b111);

      // Phase-align pulse
      applyStimulus(1, 3'b111, 1, 1, 8'd2, 0, 0);
      idle(5, 3'b111);
      applyStimulus(1, 3'b111, 0, 0, 0, 0, 1);
      idle(16, 3'b111);

      // Random traffic
      re = 3'b111;
      for (int k = 0; k < 3000; k++) begin
         logic [CNT_W-1:0] d;
         if ($urandom_range(0, 15) == 0) re = NUM_CH'($urandom);
         d = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 299) != 0), re, ($urandom_range(0, 3) == 0),
                       CH_W'($urandom_range(0, 3)), d, 1'($urandom),
                       ($urandom_range(0, 63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
